pixsel_mode_ctrl: RTL and testbench

//   Mode controller for the pixel-effect selector: owns the 8-bit effect select bus (swt code).

---
 rtl/pixsel_mode_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pixsel_mode_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pixsel_mode_ctrl.sv
// pixsel_mode_ctrl
//   Mode controller for the pixel-effect selector. Conditions the board slide
//   switches and two push-buttons, steps or auto-cycles the effect mode, and
//   commits the selected mode only on a vsync rise so that each frame is
//   rendered in a single mode.
//
// Ports
//   clk          pixel clock, all logic on posedge
//   rst          synchronous active-high reset
//   in_swt[7:0]  raw slide switches (asynchronous)
//   in_btn_next  raw "next mode" button, active-high (asynchronous)
//   in_btn_auto  raw "auto-cycle toggle" button, active-high (asynchronous)
//   in_c[2:0]    video ctrl {vsync, hsync, de}; only vsync is used here
//   out_swt[7:0] committed effect code to the pixel-effect stage
//   out_mode[3:0] committed mode index 0..9
//   out_auto     auto-cycle state active
//   out_pending  requested mode differs from committed mode
module pixsel_mode_ctrl #(
  parameter int DEB_CYCLES  = 1000000,
  parameter int AUTO_FRAMES = 120
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] in_swt,
  input  logic       in_btn_next,
  input  logic       in_btn_auto,
  input  logic [2:0] in_c,
  output logic [7:0] out_swt,
  output logic [3:0] out_mode,
  output logic       out_auto,
  output logic       out_pending
);

  localparam int DCNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int FCNT_W = (AUTO_FRAMES > 1) ? $clog2(AUTO_FRAMES) : 1;
  localparam logic [DCNT_W-1:0] DEB_LAST = DCNT_W'(DEB_CYCLES - 1);
  localparam logic [FCNT_W-1:0] FRM_LAST = FCNT_W'(AUTO_FRAMES - 1);

  typedef enum logic {ST_MANUAL = 1'b0, ST_AUTO = 1'b1} state_t;

  function automatic logic [7:0] mode_code(input logic [3:0] idx);
    case (idx)
      4'd1:    mode_code = 8'h01;
      4'd2:    mode_code = 8'h02;
      4'd3:    mode_code = 8'h04;
      4'd4:    mode_code = 8'h08;
      4'd5:    mode_code = 8'h10;
      4'd6:    mode_code = 8'h20;
      4'd7:    mode_code = 8'h40;
      4'd8:    mode_code = 8'h80;
      4'd9:    mode_code = 8'hFF;
      default: mode_code = 8'h00;
    endcase
  endfunction

  // Codes outside the table (and 0x00) map to passthrough.
  function automatic logic [3:0] code_index(input logic [7:0] code);
    case (code)
      8'h01:   code_index = 4'd1;
      8'h02:   code_index = 4'd2;
      8'h04:   code_index = 4'd3;
      8'h08:   code_index = 4'd4;
      8'h10:   code_index = 4'd5;
      8'h20:   code_index = 4'd6;
      8'h40:   code_index = 4'd7;
      8'h80:   code_index = 4'd8;
      8'hFF:   code_index = 4'd9;
      default: code_index = 4'd0;
    endcase
  endfunction

  logic [9:0]        raw;
  logic [9:0]        sync_p0;
  logic [9:0]        sync_p1;
  logic [9:0]        deb;
  logic [DCNT_W-1:0] dcnt [10];
  logic [1:0]        btn_d;
  logic              next_ev;
  logic              auto_ev;

  logic              vs_d;
  logic              vs_rise;

  state_t            state, state_nxt;
  logic [3:0]        step, step_nxt;
  logic [FCNT_W-1:0] fcnt, fcnt_nxt;
  logic              auto_adv;
  logic [3:0]        req;

  logic              unused_ctrl;
  assign unused_ctrl = ^in_c[1:0];

  assign raw = {in_btn_auto, in_btn_next, in_swt};

  // Stage p0/p1: two-flop synchronizer, then per-bit debounce
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      deb     <= '0;
      btn_d   <= '0;
      for (int i = 0; i < 10; i++) dcnt[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      btn_d   <= deb[9:8];
      for (int i = 0; i < 10; i++) begin
        if (sync_p1[i] == deb[i]) begin
          dcnt[i] <= '0;
        end else if (dcnt[i] == DEB_LAST) begin
          deb[i]  <= sync_p1[i];
          dcnt[i] <= '0;
        end else begin
          dcnt[i] <= dcnt[i] + 1'b1;
        end
      end
    end
  end

  assign next_ev = deb[8] & ~btn_d[0];
  assign auto_ev = deb[9] & ~btn_d[1];
  assign vs_rise = in_c[2] & ~vs_d;

  always_comb begin
    state_nxt = state;
    step_nxt  = step;
    fcnt_nxt  = fcnt;
    auto_adv  = 1'b0;
    req       = step;

    if (state == ST_MANUAL && deb[7:0] != 8'h00) req = code_index(deb[7:0]);

    if (state == ST_AUTO && vs_rise) begin
      if (fcnt == FRM_LAST) begin
        fcnt_nxt = '0;
        auto_adv = 1'b1;
      end else begin
        fcnt_nxt = fcnt + 1'b1;
      end
    end

    // A toggle cancels any auto-advance landing on the same edge.
    if (auto_ev) begin
      state_nxt = (state == ST_MANUAL) ? ST_AUTO : ST_MANUAL;
      fcnt_nxt  = '0;
      auto_adv  = 1'b0;
    end

    // Auto-advance and a next press together still move the step only once.
    if (auto_adv)     step_nxt = (step == 4'd9) ? 4'd1 : step + 4'd1;
    else if (next_ev) step_nxt = (step == 4'd9) ? 4'd0 : step + 4'd1;
  end

  // Stage p2: mode state and frame-boundary commit
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_MANUAL;
      step        <= '0;
      fcnt        <= '0;
      vs_d        <= 1'b0;
      out_swt     <= '0;
      out_mode    <= '0;
      out_auto    <= 1'b0;
      out_pending <= 1'b0;
    end else begin
      state       <= state_nxt;
      step        <= step_nxt;
      fcnt        <= fcnt_nxt;
      vs_d        <= in_c[2];
      out_auto    <= (state_nxt == ST_AUTO);
      out_pending <= (req != out_mode);
      if (vs_rise) begin
        out_mode <= req;
        out_swt  <= mode_code(req);
      end
    end
  end

endmodule

// File: tb/tb_pixsel_mode_ctrl.sv
module tb_pixsel_mode_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] in_swt;
  logic       in_btn_next;
  logic       in_btn_auto;
  logic [2:0] in_c;
  logic [7:0] out_swt;
  logic [3:0] out_mode;
  logic       out_auto;
  logic       out_pending;

  int errors = 0;
  int checks = 0;

  int   pos = 0;
  int   frame_no = 0;
  logic vs = 1'b1;

  pixsel_mode_ctrl #(.DEB_CYCLES(4), .AUTO_FRAMES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_swt      (in_swt),
    .in_btn_next (in_btn_next),
    .in_btn_auto (in_btn_auto),
    .in_c        (in_c),
    .out_swt     (out_swt),
    .out_mode    (out_mode),
    .out_auto    (out_auto),
    .out_pending (out_pending)
  );

  assign in_c = {vs, 1'b0, 1'b1};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Frame timing: 100 clk per frame, vsync high for positions 0..9.
  initial begin
    forever begin
      @(negedge clk);
      pos = (pos == 99) ? 0 : pos + 1;
      if (pos == 0) frame_no++;
      vs = (pos < 10);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%02h expected=0x%02h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic wait_pos(input int p);
    bit hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (pos == p) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_pos: observed=timeout expected=pos %0d", p);
    end
  endtask

  // Returns one cycle after the commit edge of the next frame.
  task automatic wait_frame();
    int  start = frame_no;
    bit  hit = 1'b0;
    for (int i = 0; i < 250; i++) begin
      tick(1);
      if (frame_no != start) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      checks++;
      errors++;
      $display("FAIL wait_frame: observed=timeout expected=vsync rise");
    end
    tick(1);
  endtask

  task automatic press_next(input int n);
    for (int i = 0; i < n; i++) begin
      in_btn_next = 1'b1;
      tick(10);
      in_btn_next = 1'b0;
      tick(10);
    end
  endtask

  initial begin
    rst         = 1'b1;
    in_swt      = 8'h10;
    in_btn_next = 1'b0;
    in_btn_auto = 1'b0;

    // Reset held across a vsync rise: everything stays at zero.
    wait_frame();
    tick(5);
    check("rst_swt", out_swt, 8'h00);
    check("rst_mode", {4'h0, out_mode}, 8'h00);
    check("rst_auto", {7'h0, out_auto}, 8'h00);
    check("rst_pend", {7'h0, out_pending}, 8'h00);

    // Switch override 0x10 commits at the first rise after debounce.
    wait_pos(20);
    rst = 1'b0;
    tick(30);
    check("sw10_pend", {7'h0, out_pending}, 8'h01);
    check("sw10_hold", out_swt, 8'h00);
    wait_frame();
    check("sw10_swt", out_swt, 8'h10);
    check("sw10_mode", {4'h0, out_mode}, 8'h05);

    // Return to passthrough, then chatter across a vsync rise.
    in_swt = 8'h00;
    wait_frame();
    check("sw00_swt", out_swt, 8'h00);
    wait_pos(80);
    for (int i = 0; i < 25; i++) begin
      in_swt = (i % 2 == 0) ? 8'h08 : 8'h00;
      tick(2);
    end
    check("bounce_swt", out_swt, 8'h00);
    check("bounce_pend", {7'h0, out_pending}, 8'h00);
    wait_frame();
    check("sw08_swt", out_swt, 8'h08);
    check("sw08_mode", {4'h0, out_mode}, 8'h04);

    // Three next presses mid-frame; commit only at vsync.
    in_swt = 8'h00;
    wait_frame();
    check("step0_mode", {4'h0, out_mode}, 8'h00);
    wait_pos(15);
    press_next(3);
    check("next3_pend", {7'h0, out_pending}, 8'h01);
    check("next3_hold", out_swt, 8'h00);
    wait_frame();
    check("next3_mode", {4'h0, out_mode}, 8'h03);
    check("next3_swt", out_swt, 8'h04);

    // Step to 9, then wrap to 0.
    press_next(6);
    wait_frame();
    check("step9_mode", {4'h0, out_mode}, 8'h09);
    check("step9_swt", out_swt, 8'hFF);
    press_next(1);
    wait_frame();
    check("wrap0_mode", {4'h0, out_mode}, 8'h00);
    check("wrap0_swt", out_swt, 8'h00);

    // Illegal switch code forces passthrough even with step=1.
    in_swt = 8'h03;
    press_next(1);
    wait_frame();
    check("ill_mode", {4'h0, out_mode}, 8'h00);
    check("ill_swt", out_swt, 8'h00);
    tick(3);
    check("ill_pend", {7'h0, out_pending}, 8'h00);
    in_swt = 8'h00;
    wait_frame();
    check("step1_mode", {4'h0, out_mode}, 8'h01);
    check("step1_swt", out_swt, 8'h01);

    // Step to 8, enter auto-cycle; switches are ignored while in AUTO.
    press_next(7);
    wait_frame();
    check("step8_mode", {4'h0, out_mode}, 8'h08);
    wait_pos(15);
    in_btn_auto = 1'b1;
    tick(10);
    in_btn_auto = 1'b0;
    tick(10);
    check("auto_on", {7'h0, out_auto}, 8'h01);
    in_swt = 8'h10;
    wait_frame();
    check("auto_f1", {4'h0, out_mode}, 8'h08);
    wait_frame();
    check("auto_f2", {4'h0, out_mode}, 8'h08);
    wait_frame();
    check("auto_f3", {4'h0, out_mode}, 8'h08);
    wait_frame();
    check("auto_f4", {4'h0, out_mode}, 8'h09);
    wait_frame();
    check("auto_f5", {4'h0, out_mode}, 8'h09);
    wait_frame();
    check("auto_f6", {4'h0, out_mode}, 8'h09);
    check("auto_f6_swt", out_swt, 8'hFF);
    wait_frame();
    check("auto_f7", {4'h0, out_mode}, 8'h01);
    check("auto_f7_swt", out_swt, 8'h01);

    // Next event lands on the same edge as the auto-advance from step 2.
    wait_frame();
    wait_frame();
    wait_frame();
    check("auto_f10", {4'h0, out_mode}, 8'h02);
    wait_frame();
    wait_pos(94);
    in_btn_next = 1'b1;
    wait_frame();
    check("coinc_f12", {4'h0, out_mode}, 8'h02);
    in_btn_next = 1'b0;
    wait_frame();
    check("coinc_f13", {4'h0, out_mode}, 8'h03);
    check("coinc_swt", out_swt, 8'h04);

    // Reset mid-frame while in AUTO.
    in_swt = 8'h00;
    wait_pos(50);
    rst = 1'b1;
    tick(1);
    check("mrst_auto", {7'h0, out_auto}, 8'h00);
    check("mrst_swt", out_swt, 8'h00);
    check("mrst_mode", {4'h0, out_mode}, 8'h00);
    tick(2);
    rst = 1'b0;
    wait_frame();
    wait_frame();
    check("post_auto", {7'h0, out_auto}, 8'h00);
    check("post_mode", {4'h0, out_mode}, 8'h00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
